// File: rtl/ball_trail_buffer.sv
// Ball trail history buffer.
// Keeps the last DEPTH accepted (x, y) samples as a shift register, newest in
// entry 0. Provides a registered random-access read port, a running mean over
// all entries, the newest-minus-previous velocity, and a saturating fill count.
// DEPTH must be a power of two and at least 2 so the mean is a plain shift.
module ball_trail_buffer #(
    parameter int COORD_W = 10,
    parameter int DEPTH   = 4,
    parameter int INIT_X  = 463,
    parameter int INIT_Y  = 275
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       sample_valid,
    input  logic [COORD_W-1:0]         x_position,
    input  logic [COORD_W-1:0]         y_position,
    input  logic [$clog2(DEPTH)-1:0]   rd_index,
    output logic [COORD_W-1:0]         rd_x,
    output logic [COORD_W-1:0]         rd_y,
    output logic [COORD_W-1:0]         avg_x,
    output logic [COORD_W-1:0]         avg_y,
    output logic signed [COORD_W:0]    vel_x,
    output logic signed [COORD_W:0]    vel_y,
    output logic [$clog2(DEPTH):0]     fill_count,
    output logic                       full
);

    localparam int IDX_W = $clog2(DEPTH);
    // DEPTH entries of COORD_W bits sum to less than 2^(COORD_W+IDX_W): no overflow.
    localparam int SUM_W = COORD_W + IDX_W;

    localparam logic [COORD_W-1:0] INIT_X_C   = COORD_W'(INIT_X);
    localparam logic [COORD_W-1:0] INIT_Y_C   = COORD_W'(INIT_Y);
    localparam logic [SUM_W-1:0]   SUM_INIT_X = SUM_W'(DEPTH * INIT_X);
    localparam logic [SUM_W-1:0]   SUM_INIT_Y = SUM_W'(DEPTH * INIT_Y);
    localparam logic [IDX_W:0]     FILL_MAX   = (IDX_W + 1)'(DEPTH);

    logic [COORD_W-1:0] x_reg  [DEPTH];
    logic [COORD_W-1:0] y_reg  [DEPTH];
    logic [COORD_W-1:0] x_next [DEPTH];
    logic [COORD_W-1:0] y_next [DEPTH];

    logic [SUM_W-1:0]   sum_x_reg, sum_x_next;
    logic [SUM_W-1:0]   sum_y_reg, sum_y_next;
    logic [IDX_W:0]     fill_reg,  fill_next;
    logic [COORD_W-1:0] rd_x_reg;
    logic [COORD_W-1:0] rd_y_reg;

    // A sample that arrives together with clear is dropped.
    logic accept;
    assign accept = sample_valid & ~clear;

    // Post-shift view of the history; the read port samples this so a read
    // issued on the same edge as a shift sees the new contents.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_shift
            if (gi == 0) begin : g_head
                assign x_next[gi] = accept ? x_position : x_reg[gi];
                assign y_next[gi] = accept ? y_position : y_reg[gi];
            end else begin : g_tail
                assign x_next[gi] = accept ? x_reg[gi-1] : x_reg[gi];
                assign y_next[gi] = accept ? y_reg[gi-1] : y_reg[gi];
            end
        end
    endgenerate

    // Running sums: add the incoming sample, drop the one falling off the end.
    always_comb begin
        sum_x_next = sum_x_reg;
        sum_y_next = sum_y_reg;
        fill_next  = fill_reg;
        if (accept) begin
            sum_x_next = sum_x_reg + SUM_W'(x_position) - SUM_W'(x_reg[DEPTH-1]);
            sum_y_next = sum_y_reg + SUM_W'(y_position) - SUM_W'(y_reg[DEPTH-1]);
            if (fill_reg != FILL_MAX) begin
                fill_next = fill_reg + 1'b1;
            end
        end
    end

    // History, sums, fill count and read port; rst and clear both restore the
    // initial trail, rst taking precedence by construction.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                x_reg[i] <= INIT_X_C;
                y_reg[i] <= INIT_Y_C;
            end
            sum_x_reg <= SUM_INIT_X;
            sum_y_reg <= SUM_INIT_Y;
            fill_reg  <= '0;
            rd_x_reg  <= INIT_X_C;
            rd_y_reg  <= INIT_Y_C;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                x_reg[i] <= x_next[i];
                y_reg[i] <= y_next[i];
            end
            sum_x_reg <= sum_x_next;
            sum_y_reg <= sum_y_next;
            fill_reg  <= fill_next;
            rd_x_reg  <= x_next[rd_index];
            rd_y_reg  <= y_next[rd_index];
        end
    end

    assign rd_x       = rd_x_reg;
    assign rd_y       = rd_y_reg;
    assign avg_x      = sum_x_reg[SUM_W-1:IDX_W];
    assign avg_y      = sum_y_reg[SUM_W-1:IDX_W];
    assign vel_x      = $signed({1'b0, x_reg[0]}) - $signed({1'b0, x_reg[1]});
    assign vel_y      = $signed({1'b0, y_reg[0]}) - $signed({1'b0, y_reg[1]});
    assign fill_count = fill_reg;
    assign full       = (fill_reg == FILL_MAX);

endmodule
